// File: rtl/serial_cmp_pkg.sv
// ---------------------------------------------------------------------------
// serial_cmp_pkg
// Shared definitions for the bit-serial magnitude comparator.
//   state_t        : controller states (2-bit encoding)
//   DEFAULT_WIDTH  : default operand width
//   RES_*          : compact result encoding, handy for debug probes
//   encode_result  : folds the gt/lt/eq flags into one RES_* code
// ---------------------------------------------------------------------------
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_GT   = 2'd1;
  localparam logic [1:0] RES_LT   = 2'd2;
  localparam logic [1:0] RES_EQ   = 2'd3;

  function automatic logic [1:0] encode_result(input logic gt, input logic lt, input logic eq);
    logic [1:0] res;
    res = RES_NONE;
    if (gt)      res = RES_GT;
    else if (lt) res = RES_LT;
    else if (eq) res = RES_EQ;
    return res;
  endfunction

endpackage

// File: rtl/comparator_1bit.sv
// ---------------------------------------------------------------------------
// comparator_1bit
// Single-bit unsigned comparator cell (purely combinational).
//   a, b : input bits
//   g    : a > b
//   l    : a < b
//   e    : a == b
// Exactly one of g/l/e is high for any input.
// ---------------------------------------------------------------------------
module comparator_1bit (
  input  logic a,
  input  logic b,
  output logic g,
  output logic l,
  output logic e
);

  assign g = a & ~b;
  assign l = ~a & b;
  assign e = ~(a ^ b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// serial_magnitude_comparator
// Bit-serial unsigned magnitude comparator. Operands are captured on an
// accepted start and fed MSB-first into a 1-bit comparator cell, one bit per
// clock, stopping at the first differing bit.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : compare request, only honoured in IDLE
//   a_in,b_in : operands, sampled on the accepted start
//   busy      : high while bits are being examined
//   done      : one-cycle pulse, results valid in the same cycle
//   gt/lt/eq  : registered result, held until the next compare completes
//   bits_used : bit positions examined by the last compare (1..WIDTH)
// ---------------------------------------------------------------------------
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [CNT_W-1:0] bits_used
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   examined_q, examined_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic               eq_q, eq_d;
  logic [CNT_W-1:0]   bits_used_q, bits_used_d;

  logic cell_g, cell_l, cell_e;

  comparator_1bit u_cell (
    .a (a_sh_q[WIDTH-1]),
    .b (b_sh_q[WIDTH-1]),
    .g (cell_g),
    .l (cell_l),
    .e (cell_e)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      examined_q  <= '0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      bits_used_q <= '0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      cnt_q       <= cnt_d;
      examined_q  <= examined_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      bits_used_q <= bits_used_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    cnt_d       = cnt_q;
    examined_d  = examined_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    bits_used_d = bits_used_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d     = a_in;
          b_sh_d     = b_in;
          cnt_d      = CNT_W'(WIDTH - 1);
          examined_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        examined_d = examined_q + 1'b1;
        // A differing bit decides immediately; equal bits only decide once
        // the LSB has been examined. The cell flags are one-hot, so they
        // can be latched directly as the result.
        if (cell_g || cell_l || (cnt_q == '0)) begin
          gt_d        = cell_g;
          lt_d        = cell_l;
          eq_d        = cell_e;
          bits_used_d = examined_q + 1'b1;
          state_d     = DONE;
        end else begin
          a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
          b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags decode straight from the state register, so they are
  // glitch-free and mutually exclusive.
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign bits_used = bits_used_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a_in, b_in;
  logic          busy, done, gt, lt, eq;
  logic [CW-1:0] bits_used;

  int n_checks = 0;
  int n_fail   = 0;

  // Result currently held by the DUT (all zero before the first compare).
  logic prev_gt = 1'b0, prev_lt = 1'b0, prev_eq = 1'b0;
  int   prev_bits = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .bits_used (bits_used)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference: bits examined = position of first differing bit from the MSB,
  // counted from 1; all WIDTH bits when the operands are equal.
  function automatic int ref_bits(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    for (int i = W - 1; i >= 0; i--)
      if (x[i]) return W - i;
    return W;
  endfunction

  // Called at a negedge with the DUT in IDLE. Drives start, then samples
  // every following negedge (cycle c) until one cycle after done.
  // mode 0: plain; 1: spurious start with FF/00 in cycle 3;
  // 2: start held high with random operands through SHIFT and DONE.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    int   k;
    logic egt, elt, eeq;
    k   = ref_bits(a, b);
    egt = (a > b);
    elt = (a < b);
    eeq = (a == b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    for (int c = 1; c <= k + 2; c++) begin
      @(negedge clk);
      if (mode == 2 && c <= k + 1) begin
        start = 1'b1;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end else if (mode == 1 && c == 3) begin
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
      end else begin
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end
      check("busy", busy, c <= k);
      check("done", done, c == k + 1);
      if (c <= k) begin
        check("gt_hold", gt, prev_gt);
        check("lt_hold", lt, prev_lt);
        check("eq_hold", eq, prev_eq);
        check("bits_hold", bits_used, prev_bits);
      end else begin
        check("gt", gt, egt);
        check("lt", lt, elt);
        check("eq", eq, eeq);
        check("bits_used", bits_used, k);
      end
    end
    $display("cmp a=%02h b=%02h mode=%0d -> gt=%0b lt=%0b eq=%0b bits_used=%0d (expect k=%0d)",
             a, b, mode, gt, lt, eq, bits_used, k);
    prev_gt   = egt;
    prev_lt   = elt;
    prev_eq   = eeq;
    prev_bits = k;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gt", gt, 0);
    check("rst_lt", lt, 0);
    check("rst_eq", eq, 0);
    check("rst_bits", bits_used, 0);
    rst = 1'b0;
    @(negedge clk);

    run_cmp(8'hA5, 8'h25, 0);   // MSB differs: done at cycle 2
    run_cmp(8'h3C, 8'h3D, 0);   // LSB differs: done at cycle 9
    run_cmp(8'h5A, 8'h5A, 0);   // equal
    run_cmp(8'hFF, 8'h00, 0);   // eq must be replaced by gt
    run_cmp(8'h10, 8'h11, 1);   // spurious start while busy is ignored
    run_cmp(8'h00, 8'h80, 2);   // start held through SHIFT and DONE
    run_cmp(8'h7E, 8'h7E, 2);   // accepted again straight after DONE

    // Reset in the middle of a compare
    start = 1'b1;
    a_in  = 8'h01;
    b_in  = 8'h02;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_gt", gt, 0);
    check("mid_rst_lt", lt, 0);
    check("mid_rst_eq", eq, 0);
    check("mid_rst_bits", bits_used, 0);
    $display("reset during compare a=01 b=02 at cycle 4 -> busy=%0b done=%0b", busy, done);
    @(negedge clk);
    rst = 1'b0;
    prev_gt = 1'b0; prev_lt = 1'b0; prev_eq = 1'b0; prev_bits = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    run_cmp(8'h80, 8'h7F, 0);

    // Random sweep, biased towards long common prefixes and equality
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp(ra, rb, ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Bit-serial N-bit magnitude comparator built around the team's single-bit comparator cell. A multi-bit compare is split into MSB-first single-bit steps. The block captures two N-bit operands on a start request and shifts them MSB-first into the cell, one bit per clock. It stops at the first differing bit and reports a registered greater/less/equal result with a one-cycle done pulse. It sits directly upstream of the 1-bit comparator and feeds it.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter and of bits_used.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a compare; accepted only in IDLE.
- a_in  in  WIDTH  operand A, sampled on the accepted start.
- b_in  in  WIDTH  operand B, sampled on the accepted start.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when a result is valid.
- gt  out  1  A > B (registered).
- lt  out  1  A < B (registered).
- eq  out  1  A == B (registered).
- bits_used  out  CNT_W  number of bit positions examined in the last compare, 1..WIDTH.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, load a_sh<=a_in and b_sh<=b_in.
  - Set cnt<=WIDTH-1 and examined<=0, then go to SHIFT.
  - With start=0, stay in IDLE.
- SHIFT:
  - Cell inputs are a_sh[WIDTH-1] and b_sh[WIDTH-1]; examined increments every SHIFT cycle.
  - Cell g=1: latch gt=1, lt=0, eq=0, go to DONE.
  - Cell l=1: latch lt=1, gt=0, eq=0, go to DONE.
  - Cell e=1 and cnt==0: latch eq=1, gt=0, lt=0, go to DONE.
  - Cell e=1 and cnt!=0: shift both registers left by one (zero fill), cnt<=cnt-1, stay in SHIFT.
- DONE:
  - done=1 for exactly this cycle; bits_used is updated in the same cycle.
  - Unconditionally return to IDLE.
- gt/lt/eq/bits_used hold their values until the next compare completes; they do not clear on start.
- Exactly one of gt/lt/eq is 1 after the first completed compare; all are 0 before it.
- Operands are unsigned.
- a_in and b_in are don't-care outside the start-accept cycle; changing them mid-compare has no effect.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, busy=0, done=0, gt=lt=eq=0, bits_used=0, shift registers and counter 0.
- Start accepted at edge 0.
- SHIFT occupies cycles 1..k, where k = 1 + (number of leading equal bits), capped at WIDTH.
- done=1 in cycle k+1, and results are visible that same cycle.
- Best-case latency is 2 cycles start-to-done (MSB differs); worst case is WIDTH+1 (equal, or only the LSB differs).
- Back-to-back starts:
  - start held high through DONE is ignored.
  - It is accepted again in the IDLE cycle that follows DONE.
  - Minimum issue interval is k+2 cycles.
- start while busy=1 or in DONE: ignored, with no operand capture and no restart.
- Reset mid-SHIFT: outputs return to reset values immediately; no done pulse is produced for the aborted compare.
- busy and done are never high in the same cycle.

## Structure
- Shared package serial_cmp_pkg:
  - state enum {IDLE, SHIFT, DONE} (2-bit encoding);
  - default WIDTH constant;
  - result encoding constants for debug.
- Sub-module: one instance of the team's single-bit comparator cell (comparator_1bit), ports a, b, g, l, e. It is driven by the two shift-register MSBs.
- All other logic (FSM, counter, shift registers, result registers) lives in this module. Target size is 150–250 lines.

## Test plan
- WIDTH=8, a=0xA5, b=0x25, start at cycle 0 -> done at cycle 2, gt=1, lt=0, eq=0, bits_used=1.
- a=0x3C, b=0x3D -> done at cycle 9, lt=1, bits_used=8.
- a=b=0x5A -> done at cycle 9, eq=1, bits_used=8; then a=0xFF, b=0x00 -> gt=1, bits_used=1, with the previous eq cleared.
- Start a=0x10, b=0x11, then pulse start with a=0xFF, b=0x00 at cycle 3 while busy -> second start ignored, final lt=1 at cycle 9, one done pulse only.
- Assert rst at cycle 4 of a=0x01, b=0x02 -> busy, done, gt, lt, eq all 0 immediately; after release, a new compare with a=0x80, b=0x7F -> gt=1 at cycle 2.
- Random sweep of 1000 operand pairs against a reference compare -> exactly one of gt/lt/eq set, result correct, bits_used = leading-equal-bits + 1 (capped at 8).
